// File: rtl/adder_gf2_pkg.sv
// Shared types and helpers for the GF(2) adder operand-join front end.
package adder_gf2_pkg;

   localparam int ADDER_GF2_WIDTH = 16;

   typedef enum logic {
      OUT_EMPTY = 1'b0,
      OUT_FULL  = 1'b1
   } out_state_t;

   function automatic logic [ADDER_GF2_WIDTH-1:0] gf2_add(
      input logic [ADDER_GF2_WIDTH-1:0] a,
      input logic [ADDER_GF2_WIDTH-1:0] b
   );
      return a ^ b;
   endfunction

endpackage

// File: rtl/adder_gf2_lane_fifo.sv
// Per-lane operand FIFO; head is read combinationally, push lands one edge later.
// Ready is registered from the post-update count, so it falls right after the filling push.
module adder_gf2_lane_fifo
   import adder_gf2_pkg::*;
#(
   parameter int WIDTH = ADDER_GF2_WIDTH,
   parameter int DEPTH = 2
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             empty,
   output logic             ready
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_next;

   always_comb begin
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ready  <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count_next;
         ready <= (count_next < CW'(DEPTH));
      end
   end

   // Storage needs no reset: count gates every read.
   always_ff @(posedge i_clock) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   assign head_data = mem[rd_ptr];
   assign empty     = (count == '0);

endmodule

// File: rtl/adder_gf2_operand_join.sv
// Joins A/B operand streams in arrival order and emits A^B on a registered valid/ready port.
// One edge from the later operand push to result; no combinational path from i_out_ready to lane readies.
module adder_gf2_operand_join
   import adder_gf2_pkg::*;
#(
   parameter int WIDTH = ADDER_GF2_WIDTH,
   parameter int DEPTH = 2
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic [WIDTH-1:0] i_a_data,
   input  logic             i_a_valid,
   output logic             o_a_ready,
   input  logic [WIDTH-1:0] i_b_data,
   input  logic             i_b_valid,
   output logic             o_b_ready,
   output logic [WIDTH-1:0] o_out_data,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [15:0]      o_xfer_count
);

   logic [WIDTH-1:0] a_head, b_head;
   logic             a_empty, b_empty;
   logic             load;
   out_state_t       state_q, state_d;

   adder_gf2_lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane_a (
      .i_clock   (i_clock),
      .i_reset   (i_reset),
      .push      (i_a_valid && o_a_ready),
      .push_data (i_a_data),
      .pop       (load),
      .head_data (a_head),
      .empty     (a_empty),
      .ready     (o_a_ready)
   );

   adder_gf2_lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane_b (
      .i_clock   (i_clock),
      .i_reset   (i_reset),
      .push      (i_b_valid && o_b_ready),
      .push_data (i_b_data),
      .pop       (load),
      .head_data (b_head),
      .empty     (b_empty),
      .ready     (o_b_ready)
   );

   // A pair moves forward whenever the output slot is free or being drained this edge.
   assign load = !a_empty && !b_empty && ((state_q == OUT_EMPTY) || i_out_ready);

   always_comb begin
      state_d = state_q;
      case (state_q)
         OUT_EMPTY: if (load) state_d = OUT_FULL;
         OUT_FULL:  if (!load && i_out_ready) state_d = OUT_EMPTY;
         default:   state_d = OUT_EMPTY;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q      <= OUT_EMPTY;
         o_out_data   <= '0;
         o_xfer_count <= '0;
      end else begin
         state_q <= state_d;
         if (load) o_out_data <= gf2_add(a_head, b_head);
         if (o_out_valid && i_out_ready) o_xfer_count <= o_xfer_count + 16'd1;
      end
   end

   assign o_out_valid = (state_q == OUT_FULL);

endmodule

// File: tb/tb_adder_gf2_operand_join.sv
// Bench for adder_gf2_operand_join: directed vector table, hand sequences, and a queue scoreboard under random traffic.
module tb_adder_gf2_operand_join;

   logic        i_clock = 1'b0;
   logic        i_reset;
   logic [15:0] i_a_data, i_b_data;
   logic        i_a_valid, i_b_valid, i_out_ready;
   logic        o_a_ready, o_b_ready, o_out_valid;
   logic [15:0] o_out_data, o_xfer_count;

   adder_gf2_operand_join #(.WIDTH(16), .DEPTH(2)) dut (
      .i_clock      (i_clock),
      .i_reset      (i_reset),
      .i_a_data     (i_a_data),
      .i_a_valid    (i_a_valid),
      .o_a_ready    (o_a_ready),
      .i_b_data     (i_b_data),
      .i_b_valid    (i_b_valid),
      .o_b_ready    (o_b_ready),
      .o_out_data   (o_out_data),
      .o_out_valid  (o_out_valid),
      .i_out_ready  (i_out_ready),
      .o_xfer_count (o_xfer_count)
   );

   always #5 i_clock = ~i_clock;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model: accepted words per lane in order; the k-th output must be A[k]^B[k].
   logic [15:0] qa[$];
   logic [15:0] qb[$];
   logic [15:0] mcnt = '0;
   bit          hold_pending = 1'b0;
   logic [15:0] hold_data = '0;

   typedef struct {
      logic        av;
      logic [15:0] a;
      logic        bv;
      logic [15:0] b;
      logic        rdy;
      logic        ev;
      logic [15:0] ed;
      logic [15:0] ec;
   } vec_t;

   vec_t tbl[11];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic step(input logic av, input logic [15:0] ad, input logic bv,
                       input logic [15:0] bd, input logic ordy, input logic rst);
      logic aacc, bacc, vpre, hs;
      logic [15:0] dpre;
      i_a_valid   = av;
      i_a_data    = ad;
      i_b_valid   = bv;
      i_b_data    = bd;
      i_out_ready = ordy;
      i_reset     = rst;
      if (hold_pending && !rst) begin
         chk("hold_valid", 32'(o_out_valid), 32'd1);
         chk("hold_data", 32'(o_out_data), 32'(hold_data));
      end
      aacc = av && o_a_ready;
      bacc = bv && o_b_ready;
      vpre = o_out_valid;
      dpre = o_out_data;
      hs   = vpre && ordy;
      @(posedge i_clock);
      #1;
      if (rst) begin
         qa.delete();
         qb.delete();
         mcnt = '0;
         hold_pending = 1'b0;
      end else begin
         if (aacc) qa.push_back(ad);
         if (bacc) qb.push_back(bd);
         if (hs) begin
            chk("sb_pair_avail", 32'(qa.size() != 0 && qb.size() != 0), 32'd1);
            if (qa.size() != 0 && qb.size() != 0)
               chk("sb_data", 32'(dpre), 32'(qa.pop_front() ^ qb.pop_front()));
            mcnt = mcnt + 16'd1;
         end
         hold_pending = vpre && !ordy;
         hold_data    = dpre;
         chk("sb_count", 32'(o_xfer_count), 32'(mcnt));
      end
   endtask

   task automatic idle(input logic ordy);
      step(1'b0, 16'h0, 1'b0, 16'h0, ordy, 1'b0);
   endtask

   initial begin
      int pend;
      // Aligned stream of three pairs, then a skewed pair (B three cycles after A).
      tbl[0]  = '{1'b1, 16'h00FF, 1'b1, 16'h0F0F, 1'b1, 1'b0, 16'h0000, 16'd0};
      tbl[1]  = '{1'b1, 16'h1234, 1'b1, 16'h1234, 1'b1, 1'b1, 16'h0FF0, 16'd0};
      tbl[2]  = '{1'b1, 16'hAAAA, 1'b1, 16'h5555, 1'b1, 1'b1, 16'h0000, 16'd1};
      tbl[3]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 16'd2};
      tbl[4]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 16'd3};
      tbl[5]  = '{1'b1, 16'hF000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 16'd3};
      tbl[6]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 16'd3};
      tbl[7]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 16'd3};
      tbl[8]  = '{1'b0, 16'h0000, 1'b1, 16'h000F, 1'b1, 1'b0, 16'hFFFF, 16'd3};
      tbl[9]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hF00F, 16'd3};
      tbl[10] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'hF00F, 16'd4};

      i_reset = 1'b1; i_a_valid = 1'b0; i_b_valid = 1'b0; i_out_ready = 1'b0;
      i_a_data = '0; i_b_data = '0;
      repeat (2) step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
      chk("rst_a_ready", 32'(o_a_ready), 32'd0);
      chk("rst_b_ready", 32'(o_b_ready), 32'd0);
      chk("rst_valid", 32'(o_out_valid), 32'd0);
      chk("rst_data", 32'(o_out_data), 32'd0);
      chk("rst_count", 32'(o_xfer_count), 32'd0);
      idle(1'b1);
      chk("post_rst_a_ready", 32'(o_a_ready), 32'd1);
      chk("post_rst_b_ready", 32'(o_b_ready), 32'd1);

      for (int i = 0; i < 11; i++) begin
         step(tbl[i].av, tbl[i].a, tbl[i].bv, tbl[i].b, tbl[i].rdy, 1'b0);
         chk($sformatf("vec%0d_valid", i), 32'(o_out_valid), 32'(tbl[i].ev));
         chk($sformatf("vec%0d_data", i), 32'(o_out_data), 32'(tbl[i].ed));
         chk($sformatf("vec%0d_count", i), 32'(o_xfer_count), 32'(tbl[i].ec));
         chk($sformatf("vec%0d_a_ready", i), 32'(o_a_ready), 32'd1);
         chk($sformatf("vec%0d_b_ready", i), 32'(o_b_ready), 32'd1);
      end

      // Back-pressure: one result held, each lane fills to DEPTH, fourth pair refused.
      step(1'b1, 16'h1111, 1'b1, 16'h0001, 1'b0, 1'b0);
      step(1'b1, 16'h2222, 1'b1, 16'h0002, 1'b0, 1'b0);
      chk("bp_first_valid", 32'(o_out_valid), 32'd1);
      chk("bp_first_data", 32'(o_out_data), 32'h1110);
      step(1'b1, 16'h3333, 1'b1, 16'h0003, 1'b0, 1'b0);
      chk("bp_full_a_ready", 32'(o_a_ready), 32'd0);
      chk("bp_full_b_ready", 32'(o_b_ready), 32'd0);
      repeat (2) step(1'b1, 16'h4444, 1'b1, 16'h0004, 1'b0, 1'b0);
      chk("bp_held_data", 32'(o_out_data), 32'h1110);
      chk("bp_held_a_ready", 32'(o_a_ready), 32'd0);
      idle(1'b1);
      chk("bp_drain1", 32'(o_out_data), 32'h2220);
      chk("bp_recover_a_ready", 32'(o_a_ready), 32'd1);
      chk("bp_recover_b_ready", 32'(o_b_ready), 32'd1);
      idle(1'b1);
      chk("bp_drain2", 32'(o_out_data), 32'h3330);
      chk("bp_drain2_valid", 32'(o_out_valid), 32'd1);
      idle(1'b1);
      chk("bp_empty", 32'(o_out_valid), 32'd0);
      chk("bp_count", 32'(o_xfer_count), 32'd7);
      idle(1'b1);
      chk("bp_no_extra", 32'(o_out_valid), 32'd0);

      // Reset while lanes are full and the output is valid.
      repeat (3) step(1'b1, 16'h5555, 1'b1, 16'h0505, 1'b0, 1'b0);
      chk("mid_pre_valid", 32'(o_out_valid), 32'd1);
      chk("mid_pre_a_ready", 32'(o_a_ready), 32'd0);
      step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
      chk("mid_rst_valid", 32'(o_out_valid), 32'd0);
      chk("mid_rst_data", 32'(o_out_data), 32'd0);
      chk("mid_rst_count", 32'(o_xfer_count), 32'd0);
      chk("mid_rst_a_ready", 32'(o_a_ready), 32'd0);
      chk("mid_rst_b_ready", 32'(o_b_ready), 32'd0);
      idle(1'b1);
      chk("mid_rec_a_ready", 32'(o_a_ready), 32'd1);
      chk("mid_rec_b_ready", 32'(o_b_ready), 32'd1);
      repeat (2) begin
         idle(1'b1);
         chk("mid_no_stale", 32'(o_out_valid), 32'd0);
      end

      // Counter wrap after 65535 streamed transfers.
      for (int i = 0; i < 70000 && mcnt != 16'hFFFF; i++)
         step(1'b1, 16'($urandom), 1'b1, 16'($urandom), 1'b1, 1'b0);
      chk("wrap_reached", 32'(mcnt), 32'hFFFF);
      chk("wrap_pre", 32'(o_xfer_count), 32'hFFFF);
      step(1'b1, 16'($urandom), 1'b1, 16'($urandom), 1'b1, 1'b0);
      chk("wrap_zero", 32'(o_xfer_count), 32'd0);

      // Random traffic against the scoreboard.
      repeat (2) step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
      for (int i = 0; i < 10000; i++)
         step($urandom_range(0, 9) < 7, 16'($urandom), $urandom_range(0, 9) < 7,
              16'($urandom), $urandom_range(0, 9) < 6, 1'b0);
      repeat (20) idle(1'b1);
      pend = (qa.size() < qb.size()) ? qa.size() : qb.size();
      chk("rand_pairs_drained", 32'(pend), 32'd0);
      chk("rand_final_valid", 32'(o_out_valid), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
